// File: rtl/mips_multicycle_control_pkg.sv
// rtl/mips_multicycle_control_pkg.sv - opcode/funct constants, state encodings and control codes
package mips_multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       jal_signal;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - IR fields, memory handshake and datapath control bundle
interface mips_multicycle_control_if #(parameter int STATE_W = 4);

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic [1:0]         pc_source;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic               reg_dest;
  logic               mem_to_reg;
  logic               jal_signal;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic               illegal_op;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dest, mem_to_reg, jal_signal, alu_src_a, alu_src_b, alu_op,
           illegal_op, state_dbg
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dest, mem_to_reg, jal_signal, alu_src_a, alu_src_b, alu_op,
           illegal_op, state_dbg
  );

endinterface

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational state+opcode to datapath control decode
module mips_ctrl_decode
  import mips_multicycle_control_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // IR and PC only load in the cycle the fetch actually completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMM_SH;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.illegal_op = !is_legal_op(opcode_i);
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I, S_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_WB_ALU: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dest  = (opcode_i == OP_RTYPE);
      end
      S_WB_MEM: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        // only jr reaches JUMP with an R-type opcode
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = (opcode_i == OP_RTYPE) ? PCSRC_RS : PCSRC_JUMP;
        ctrl_o.reg_write  = (opcode_i == OP_JAL);
        ctrl_o.jal_signal = (opcode_i == OP_JAL);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS control FSM; MIPS_CTRL_PERF_EN adds cycle/retire counters
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  mips_multicycle_control_if.master bus
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0]               cycle_count,
  output logic [31:0]               retire_count
`endif
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = (bus.funct == FN_JR) ? S_JUMP : S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J, OP_JAL: state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR:   state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: state_d = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  // reset forces every control low, so an abandoned instruction never writes
  assign ctrl_out          = reset ? '0 : ctrl;
  assign bus.pc_write      = ctrl_out.pc_write;
  assign bus.pc_write_cond = ctrl_out.pc_write_cond;
  assign bus.pc_source     = ctrl_out.pc_source;
  assign bus.i_or_d        = ctrl_out.i_or_d;
  assign bus.mem_read      = ctrl_out.mem_read;
  assign bus.mem_write     = ctrl_out.mem_write;
  assign bus.ir_write      = ctrl_out.ir_write;
  assign bus.reg_write     = ctrl_out.reg_write;
  assign bus.reg_dest      = ctrl_out.reg_dest;
  assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
  assign bus.jal_signal    = ctrl_out.jal_signal;
  assign bus.alu_src_a     = ctrl_out.alu_src_a;
  assign bus.alu_src_b     = ctrl_out.alu_src_b;
  assign bus.alu_op        = ctrl_out.alu_op;
  assign bus.illegal_op    = ctrl_out.illegal_op;
  assign bus.state_dbg     = reset ? '0 : STATE_W'(state_q);

`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_q, retire_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (state_d == S_FETCH && state_q != S_FETCH && !ctrl.illegal_op)
        retire_q <= retire_q + 32'd1;
    end
  end

  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
`endif

endmodule
